// File: rtl/ion_stream_reader_if.sv
// Byte-stream handshake between the ion stream reader and the UART transmitter path.
// The master presents framed bytes with their frame index; the slave acknowledges them.
interface ion_stream_reader_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ack;
    logic [3:0] index;

    modport master (output byte_out, output byte_valid, output index, input byte_ack);
    modport slave  (input byte_out, input byte_valid, input index, output byte_ack);
endinterface

// File: rtl/ion_stream_reader.sv
// Captures one ion sensor record on the selected channel's ready rising edge and
// streams it as a 16-byte frame: header, 14 payload bytes (MSB first), XOR checksum.
module ion_stream_reader #(
    parameter logic [7:0] HEADER = 8'hA5,
    parameter int         DATA_W = 110
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        sensor_ready,
    input  logic [DATA_W-1:0] sensor_data,
    input  logic [2:0]        channel_sel,
    ion_stream_reader_if.master bus,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        overrun_count
);
    localparam int REC_W = 112;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_CHK  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [REC_W-1:0] shift_q, shift_d;
    logic [7:0]       chk_q, chk_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       ready_prev_q, ready_prev_d;
    logic [7:0]       overrun_q, overrun_d;
    logic             frame_done_q, frame_done_d;

    logic rise;
    logic accept;

    assign rise   = sensor_ready[channel_sel] & ~ready_prev_q[channel_sel];
    assign accept = bus.byte_valid & bus.byte_ack;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        chk_d        = chk_q;
        idx_d        = idx_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        ready_prev_d = sensor_ready;

        // A rise while a frame is in flight (including its final ack cycle) is dropped.
        if (rise && (state_q != S_IDLE) && (overrun_q != 8'hFF))
            overrun_d = overrun_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    shift_d = {{(REC_W-DATA_W){1'b0}}, sensor_data};
                    chk_d   = HEADER;
                    idx_d   = 4'd0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    idx_d   = 4'd1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    shift_d = shift_q << 8;
                    chk_d   = chk_q ^ shift_q[REC_W-1 -: 8];
                    if (idx_q == 4'd14) begin
                        idx_d   = 4'd15;
                        state_d = S_CHK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    frame_done_d = 1'b1;
                    idx_d        = 4'd0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            chk_q        <= '0;
            idx_q        <= '0;
            ready_prev_q <= '0;
            overrun_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            chk_q        <= chk_d;
            idx_q        <= idx_d;
            ready_prev_q <= ready_prev_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        case (state_q)
            S_HDR:   bus.byte_out = HEADER;
            S_DATA:  bus.byte_out = shift_q[REC_W-1 -: 8];
            S_CHK:   bus.byte_out = chk_q;
            default: bus.byte_out = 8'h00;
        endcase
    end

    assign bus.byte_valid = (state_q != S_IDLE);
    assign bus.index      = idx_q;
    assign busy           = (state_q != S_IDLE);
    assign frame_done     = frame_done_q;
    assign overrun_count  = overrun_q;
endmodule

// File: tb/tb_ion_stream_reader.sv
// Scoreboard bench for ion_stream_reader: stimulus queues expected frame bytes,
// a negedge monitor pops and compares every accepted byte.
module tb_ion_stream_reader;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   sensor_ready = 8'h00;
    logic [109:0] sensor_data = '0;
    logic [2:0]   channel_sel = 3'd0;
    logic         busy;
    logic         frame_done;
    logic [7:0]   overrun_count;

    ion_stream_reader_if bus();

    ion_stream_reader dut (
        .clock         (clock),
        .reset         (reset),
        .sensor_ready  (sensor_ready),
        .sensor_data   (sensor_data),
        .channel_sel   (channel_sel),
        .bus           (bus.master),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun_count (overrun_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    localparam logic [109:0] D_ONES = '1;
    localparam logic [109:0] D_A    = 110'h2AB_0123_4567_89AB_CDEF_0123_4567;
    localparam logic [109:0] D_B    = 110'h3FFF_0000_1111_2222_3333_4444_5555;
    localparam logic [109:0] D_C    = 110'h1_DEAD_BEEF_CAFE_F00D_1234_5678_9A;
    localparam logic [109:0] D_D    = 110'h0_0F0F_F0F0_5A5A_A5A5_C3C3_3C3C_77;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] idx, input logic [7:0] b);
        exp_t e;
        e.idx = idx;
        e.b   = b;
        sb.push_back(e);
    endtask

    // Reference frame: header, record padded to 112 bits sent MSB first, XOR of all prior bytes.
    task automatic push_frame(input logic [109:0] d);
        logic [111:0] r;
        logic [7:0]   c;
        logic [7:0]   b;
        r = {2'b00, d};
        c = 8'hA5;
        push(4'd0, 8'hA5);
        for (int i = 0; i < 14; i++) begin
            b = r[111 - 8*i -: 8];
            c = c ^ b;
            push(4'(i + 1), b);
        end
        push(4'd15, c);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (frame_done) done_cnt++;
            if (bus.byte_valid && bus.byte_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_byte", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("byte", {24'd0, bus.byte_out}, {24'd0, e.b});
                    check("index", {28'd0, bus.index}, {28'd0, e.idx});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise the channel's ready bit, then drive ack until frame_done. Optional stall at
    // stall_idx for stall_len cycles and an extra rise (new data) at rise_idx.
    task automatic run_frame(input int ch, input logic [109:0] d, input int stall_idx,
                             input int stall_len, input int rise_idx,
                             input logic [109:0] d2, input int exp_cycles);
        int cycles = 0;
        int stalled = 0;
        int start_done;
        bit rised = 0;
        sensor_data      = d;
        sensor_ready[ch] = 1'b1;
        tick();
        check("valid_latency", {31'd0, bus.byte_valid}, 32'd1);
        check("busy_after_capture", {31'd0, busy}, 32'd1);
        sensor_ready[ch] = 1'b0;
        start_done = done_cnt;
        while (!frame_done && cycles < 400) begin
            if (rise_idx >= 0 && !rised && bus.index == 4'(rise_idx)) begin
                sensor_ready[ch] = 1'b1;
                sensor_data      = d2;
                rised            = 1;
            end
            if (bus.index == 4'(stall_idx) && stalled < stall_len) begin
                bus.byte_ack = 1'b0;
                check("hold_byte", {24'd0, bus.byte_out}, 32'hFF);
                check("hold_index", {28'd0, bus.index}, stall_idx);
                stalled++;
            end else begin
                bus.byte_ack = 1'b1;
            end
            tick();
            cycles++;
        end
        check("frame_cycles", cycles, exp_cycles);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("valid_at_done", {31'd0, bus.byte_valid}, 32'd0);
        tick();
        check("done_pulse_width", {31'd0, frame_done}, 32'd0);
        check("done_count", done_cnt - start_done, 32'd1);
        check("sb_empty", sb.size(), 32'd0);
        sensor_ready[ch] = 1'b0;
    endtask

    initial begin
        int n;
        int d0;
        bus.byte_ack = 1'b0;

        // Reset
        repeat (4) tick();
        reset = 1'b0;
        check("rst_valid", {31'd0, bus.byte_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_index", {28'd0, bus.index}, 32'd0);
        check("rst_byte", {24'd0, bus.byte_out}, 32'd0);
        check("rst_overrun", {24'd0, overrun_count}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        tick();

        // Basic frame, hand-computed bytes
        channel_sel = 3'd0;
        push(4'd0, 8'hA5);
        push(4'd1, 8'h3F);
        for (int i = 2; i <= 14; i++) push(4'(i), 8'hFF);
        push(4'd15, 8'h65);
        run_frame(0, D_ONES, -1, 0, -1, '0, 16);
        tick();

        // Backpressure at index 3
        push(4'd0, 8'hA5);
        push(4'd1, 8'h3F);
        for (int i = 2; i <= 14; i++) push(4'(i), 8'hFF);
        push(4'd15, 8'h65);
        run_frame(0, D_ONES, 3, 5, -1, '0, 21);
        tick();

        // Overrun: second rise at index 6 with different data is dropped
        channel_sel = 3'd2;
        push_frame(D_A);
        run_frame(2, D_A, -1, 0, 6, D_B, 16);
        check("overrun_one", {24'd0, overrun_count}, 32'd1);
        repeat (20) tick();
        check("no_second_frame", {31'd0, bus.byte_valid}, 32'd0);
        check("no_second_frame_sb", sb.size(), 32'd0);

        // Level hold on channel 5, then toggle of unselected bit 3
        channel_sel      = 3'd5;
        bus.byte_ack     = 1'b1;
        d0               = done_cnt;
        push_frame(D_C);
        sensor_data      = D_C;
        sensor_ready[5]  = 1'b1;
        repeat (100) tick();
        check("level_one_frame", done_cnt - d0, 32'd1);
        check("level_sb_empty", sb.size(), 32'd0);
        sensor_ready[5] = 1'b0;
        tick();
        d0 = done_cnt;
        sensor_ready[3] = 1'b1;
        repeat (3) tick();
        sensor_ready[3] = 1'b0;
        repeat (30) tick();
        check("unselected_no_frame", done_cnt - d0, 32'd0);
        check("unselected_idle", {31'd0, bus.byte_valid}, 32'd0);

        // Reset mid-frame at index 9
        d0 = done_cnt;
        push_frame(D_D);
        sensor_data     = D_D;
        sensor_ready[5] = 1'b1;
        n = 0;
        while (!(bus.byte_valid && bus.index == 4'd9) && n < 50) begin
            tick();
            n++;
        end
        check("reached_index9", {31'd0, bus.byte_valid}, 32'd1);
        reset           = 1'b1;
        sensor_ready[5] = 1'b0;
        tick();
        reset = 1'b0;
        check("midrst_valid", {31'd0, bus.byte_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_overrun", {24'd0, overrun_count}, 32'd0);
        sb.delete();
        tick();
        check("midrst_no_done", done_cnt - d0, 32'd0);
        push_frame(D_B);
        run_frame(5, D_B, -1, 0, -1, '0, 16);

        // Saturation: 300 rises with ack low, then 5 more
        channel_sel     = 3'd1;
        bus.byte_ack    = 1'b0;
        push_frame(D_A);
        sensor_data     = D_A;
        sensor_ready[1] = 1'b1;
        tick();
        check("sat_busy", {31'd0, busy}, 32'd1);
        sensor_data = D_B;
        for (int i = 0; i < 300; i++) begin
            sensor_ready[1] = 1'b0;
            tick();
            sensor_ready[1] = 1'b1;
            tick();
        end
        check("sat_255", {24'd0, overrun_count}, 32'd255);
        for (int i = 0; i < 5; i++) begin
            sensor_ready[1] = 1'b0;
            tick();
            sensor_ready[1] = 1'b1;
            tick();
        end
        check("sat_stays_255", {24'd0, overrun_count}, 32'd255);
        sensor_ready[1] = 1'b0;
        d0           = done_cnt;
        bus.byte_ack = 1'b1;
        n = 0;
        while (!frame_done && n < 50) begin
            tick();
            n++;
        end
        check("sat_drain_cycles", n, 32'd16);
        tick();
        check("sat_drain_done", done_cnt - d0, 32'd1);
        check("sat_sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
